// File: rtl/xintf_dsp_bridge.sv
// DSP-side front end of the XINTF shared BRAM.
// Synchronises the asynchronous XINTF strobes into i_clk, turns each DSP bus
// cycle into a single BRAM port-B access and raises the block handshakes
// (o_w_ready / o_r_valid) consumed by the FPGA-side DSP handler.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a synced strobe falling edge with cs_n low
// WR_CAP   | single BRAM write cycle (or error if below WR_BASE)
// RD_ADDR  | BRAM read address presented
// RD_DATA  | BRAM read data captured into the pad register
// WAIT_END | holding pad data until both strobes are released
module xintf_dsp_bridge #(
  parameter int SYNC_STAGES   = 2,
  parameter int W_ACK_ADDR    = 47,
  parameter int R_COMMIT_ADDR = 176,
  parameter int WR_BASE       = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_xintf_cs_n,
  input  logic        i_xintf_we_n,
  input  logic        i_xintf_rd_n,
  input  logic [8:0]  i_xintf_addr,
  input  logic [15:0] i_xintf_data_in,
  output logic [15:0] o_xintf_data_out,
  output logic        o_xintf_data_oe,
  output logic [8:0]  o_ram_addr,
  output logic [15:0] o_ram_din,
  output logic        o_ram_ce,
  output logic        o_ram_we,
  input  logic [15:0] i_ram_dout,
  input  logic        i_w_valid,
  output logic        o_w_ready,
  output logic        o_r_valid,
  output logic [7:0]  o_err_cnt,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_CAP   = 3'd1,
    S_RD_ADDR  = 3'd2,
    S_RD_DATA  = 3'd3,
    S_WAIT_END = 3'd4
  } state_t;

  localparam logic [8:0] LP_W_ACK    = 9'(W_ACK_ADDR);
  localparam logic [8:0] LP_R_COMMIT = 9'(R_COMMIT_ADDR);
  localparam logic [8:0] LP_WR_BASE  = 9'(WR_BASE);

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_we_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic r_we_prev;
  logic r_rd_prev;

  logic [8:0]  r_addr;
  logic [15:0] r_data;
  logic        r_is_rd;
  logic [15:0] r_dout;
  logic        r_oe;
  logic [7:0]  r_err_cnt;
  logic        r_lock;

  logic w_cs_s;
  logic w_we_s;
  logic w_rd_s;
  logic w_start_wr;
  logic w_start_rd;

  logic w_ram_ce;
  logic w_ram_we;
  logic w_r_valid;
  logic w_w_ready;
  logic w_capture;
  logic w_capture_rd;
  logic w_err_inc;
  logic w_lock_set;
  logic w_rd_latch;
  logic w_oe_clr;

  assign w_cs_s = r_cs_sync[SYNC_STAGES-1];
  assign w_we_s = r_we_sync[SYNC_STAGES-1];
  assign w_rd_s = r_rd_sync[SYNC_STAGES-1];

  // A start is a synced falling strobe edge qualified by a selected zone.
  assign w_start_wr = ~w_cs_s & r_we_prev & ~w_we_s;
  assign w_start_rd = ~w_cs_s & r_rd_prev & ~w_rd_s;

  // Strobe synchronisers plus one edge-detect stage; all idle high out of reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cs_sync <= '1;
      r_we_sync <= '1;
      r_rd_sync <= '1;
      r_we_prev <= 1'b1;
      r_rd_prev <= 1'b1;
    end else begin
      r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], i_xintf_cs_n};
      r_we_sync <= {r_we_sync[SYNC_STAGES-2:0], i_xintf_we_n};
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], i_xintf_rd_n};
      r_we_prev <= w_we_s;
      r_rd_prev <= w_rd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state strobes for the BRAM, handshakes and datapath.
  always_comb begin
    w_state_nxt  = r_state;
    w_ram_ce     = 1'b0;
    w_ram_we     = 1'b0;
    w_r_valid    = 1'b0;
    w_w_ready    = 1'b0;
    w_capture    = 1'b0;
    w_capture_rd = 1'b0;
    w_err_inc    = 1'b0;
    w_lock_set   = 1'b0;
    w_rd_latch   = 1'b0;
    w_oe_clr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Both strobes low is an illegal cycle: count it once, then ignore
        // everything until both strobes have been released.
        if (!w_cs_s && !w_we_s && !w_rd_s) begin
          if (!r_lock) begin
            w_err_inc  = 1'b1;
            w_lock_set = 1'b1;
          end
        end else if (!r_lock && w_start_wr) begin
          w_capture   = 1'b1;
          w_state_nxt = S_WR_CAP;
        end else if (!r_lock && w_start_rd) begin
          w_capture    = 1'b1;
          w_capture_rd = 1'b1;
          w_state_nxt  = S_RD_ADDR;
        end
      end
      S_WR_CAP: begin
        if (r_addr >= LP_WR_BASE) begin
          w_ram_ce = 1'b1;
          w_ram_we = 1'b1;
        end else begin
          w_err_inc = 1'b1;
        end
        if (r_addr == LP_R_COMMIT) begin
          w_r_valid = 1'b1;
        end
        w_state_nxt = S_WAIT_END;
      end
      S_RD_ADDR: begin
        w_ram_ce    = 1'b1;
        w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        w_rd_latch  = 1'b1;
        w_state_nxt = S_WAIT_END;
      end
      S_WAIT_END: begin
        // cs_n is deliberately not looked at: only strobe release ends a cycle.
        if (w_we_s && w_rd_s) begin
          w_oe_clr = 1'b1;
          if (r_is_rd && (r_addr == LP_W_ACK) && i_w_valid) begin
            w_w_ready = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus-cycle capture, pad data register, error counter and illegal-cycle lock.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_is_rd   <= 1'b0;
      r_dout    <= '0;
      r_oe      <= 1'b0;
      r_err_cnt <= '0;
      r_lock    <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr  <= i_xintf_addr;
        r_data  <= i_xintf_data_in;
        r_is_rd <= w_capture_rd;
      end
      if (w_rd_latch) begin
        r_dout <= i_ram_dout;
        r_oe   <= 1'b1;
      end else if (w_oe_clr) begin
        r_oe <= 1'b0;
      end
      if (w_err_inc && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_lock_set) begin
        r_lock <= 1'b1;
      end else if (w_we_s && w_rd_s) begin
        r_lock <= 1'b0;
      end
    end
  end

  assign o_ram_ce         = w_ram_ce;
  assign o_ram_we         = w_ram_we;
  assign o_ram_addr       = w_ram_ce ? r_addr : 9'd0;
  assign o_ram_din        = w_ram_we ? r_data : 16'd0;
  assign o_r_valid        = w_r_valid;
  assign o_w_ready        = w_w_ready;
  assign o_xintf_data_out = r_dout;
  assign o_xintf_data_oe  = r_oe;
  assign o_err_cnt        = r_err_cnt;
  assign o_state          = r_state;

endmodule

// File: tb/tb_xintf_dsp_bridge.sv
// Bench for xintf_dsp_bridge: directed scenarios plus randomized DSP bus
// cycles, checked against an address-region model of the shared memory.
module tb_xintf_dsp_bridge;

  localparam int SYNC = 2;
  localparam int WR_LAT = SYNC + 1;
  localparam int RD_LAT = SYNC + 3;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_xintf_cs_n;
  logic        i_xintf_we_n;
  logic        i_xintf_rd_n;
  logic [8:0]  i_xintf_addr;
  logic [15:0] i_xintf_data_in;
  logic [15:0] o_xintf_data_out;
  logic        o_xintf_data_oe;
  logic [8:0]  o_ram_addr;
  logic [15:0] o_ram_din;
  logic        o_ram_ce;
  logic        o_ram_we;
  logic [15:0] i_ram_dout;
  logic        i_w_valid;
  logic        o_w_ready;
  logic        o_r_valid;
  logic [7:0]  o_err_cnt;
  logic [2:0]  o_state;

  always #5 i_clk = ~i_clk;

  xintf_dsp_bridge #(
    .SYNC_STAGES(SYNC), .W_ACK_ADDR(47), .R_COMMIT_ADDR(176), .WR_BASE(128)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_xintf_cs_n(i_xintf_cs_n), .i_xintf_we_n(i_xintf_we_n), .i_xintf_rd_n(i_xintf_rd_n),
    .i_xintf_addr(i_xintf_addr), .i_xintf_data_in(i_xintf_data_in),
    .o_xintf_data_out(o_xintf_data_out), .o_xintf_data_oe(o_xintf_data_oe),
    .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din), .o_ram_ce(o_ram_ce), .o_ram_we(o_ram_we),
    .i_ram_dout(i_ram_dout), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
    .o_r_valid(o_r_valid), .o_err_cnt(o_err_cnt), .o_state(o_state)
  );

  // Port-B BRAM with 1-cycle read latency and a preload port for the bench.
  logic [15:0] mem [0:511];
  logic        pl_we = 1'b0;
  logic [8:0]  pl_addr = 9'd0;
  logic [15:0] pl_data = 16'd0;
  always @(posedge i_clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (o_ram_ce) begin
      if (o_ram_we) mem[o_ram_addr] <= o_ram_din;
      i_ram_dout <= mem[o_ram_addr];
    end
  end

  // Passive monitor: running totals of pulses and timing of key events.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int tot_we = 0, tot_ce = 0, tot_rv = 0, tot_wr = 0, consec = 0;
  int last_we_cyc = 0, last_oe_cyc = 0;
  logic [8:0]  last_we_addr = 9'd0;
  logic [15:0] last_we_din = 16'd0, last_oe_data = 16'd0;
  logic p_ce = 1'b0, p_we = 1'b0, p_rv = 1'b0, p_wr = 1'b0, p_oe = 1'b0;
  always @(negedge i_clk) begin
    if (o_ram_we) begin
      tot_we       <= tot_we + 1;
      last_we_cyc  <= cyc;
      last_we_addr <= o_ram_addr;
      last_we_din  <= o_ram_din;
    end
    if (o_ram_ce) tot_ce <= tot_ce + 1;
    if (o_r_valid) tot_rv <= tot_rv + 1;
    if (o_w_ready) tot_wr <= tot_wr + 1;
    if ((o_ram_ce && p_ce) || (o_ram_we && p_we) || (o_r_valid && p_rv) || (o_w_ready && p_wr))
      consec <= consec + 1;
    if (o_xintf_data_oe && !p_oe) begin
      last_oe_cyc  <= cyc;
      last_oe_data <= o_xintf_data_out;
    end
    p_ce <= o_ram_ce;
    p_we <= o_ram_we;
    p_rv <= o_r_valid;
    p_wr <= o_w_ready;
    p_oe <= o_xintf_data_oe;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  // Reference model: memory contents as the DSP should see them, and error count.
  logic [15:0] ref_mem [0:255];
  int ref_err = 0;

  int fall_cyc, s_we, s_ce, s_rv, s_wr, pre_wr;

  task automatic bus_op(input bit is_wr, input logic [8:0] a, input logic [15:0] d, input int hold);
    s_we = tot_we; s_ce = tot_ce; s_rv = tot_rv; s_wr = tot_wr;
    i_xintf_addr    = a;
    i_xintf_data_in = d;
    i_xintf_cs_n    = 1'b0;
    if (is_wr) i_xintf_we_n = 1'b0;
    else       i_xintf_rd_n = 1'b0;
    fall_cyc = cyc;
    repeat (hold) step();
    pre_wr = tot_wr - s_wr;
    i_xintf_we_n = 1'b1;
    i_xintf_rd_n = 1'b1;
    i_xintf_cs_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    bit exp_we;
    exp_we = (a >= 9'd128);
    bus_op(1'b1, a, d, 4);
    if (exp_we) ref_mem[a[7:0]] = d;
    else if (ref_err < 255) ref_err++;
    check("wr_we_pulses", tot_we - s_we, 32'(exp_we));
    if (exp_we) begin
      check("wr_latency", last_we_cyc - fall_cyc, WR_LAT);
      check("wr_addr", 32'(last_we_addr), 32'(a));
      check("wr_din", 32'(last_we_din), 32'(d));
    end
    check("wr_r_valid", tot_rv - s_rv, 32'(a == 9'd176));
    check("wr_err_cnt", 32'(o_err_cnt), ref_err);
    check("wr_idle", 32'(o_state), 32'd0);
  endtask

  task automatic do_read(input logic [8:0] a, input bit wv);
    i_w_valid = wv;
    bus_op(1'b0, a, 16'h0000, 8);
    check("rd_data", 32'(last_oe_data), 32'(ref_mem[a[7:0]]));
    check("rd_latency", last_oe_cyc - fall_cyc, RD_LAT);
    check("rd_no_early_w_ready", pre_wr, 32'd0);
    check("rd_w_ready", tot_wr - s_wr, 32'((a == 9'd47) && wv));
    check("rd_no_we", tot_we - s_we, 32'd0);
    check("rd_oe_released", 32'(o_xintf_data_oe), 32'd0);
    check("rd_err_cnt", 32'(o_err_cnt), ref_err);
    i_w_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]  a;
    logic [15:0] d;
    int k;
    i_rst = 1'b1;
    i_xintf_cs_n = 1'b1; i_xintf_we_n = 1'b1; i_xintf_rd_n = 1'b1;
    i_xintf_addr = 9'd0; i_xintf_data_in = 16'd0; i_w_valid = 1'b0;
    #1 i_rst = 1'b0;
    step();

    check("rst_state", 32'(o_state), 32'd0);
    check("rst_oe", 32'(o_xintf_data_oe), 32'd0);
    check("rst_data_out", 32'(o_xintf_data_out), 32'd0);
    check("rst_ram_ce_we", 32'({o_ram_ce, o_ram_we}), 32'd0);
    check("rst_ram_addr_din", 32'({o_ram_addr, o_ram_din}), 32'd0);
    check("rst_pulses", 32'({o_r_valid, o_w_ready}), 32'd0);
    check("rst_err_cnt", 32'(o_err_cnt), 32'd0);

    // Preload the shared memory while the bridge is held in reset.
    for (int i = 0; i < 256; i++) begin
      d = (i == 40) ? 16'hBEEF : 16'($urandom);
      ref_mem[i] = d;
      pl_addr = 9'(i); pl_data = d; pl_we = 1'b1;
      step();
    end
    pl_we = 1'b0;
    step();
    i_rst = 1'b1;
    repeat (3) step();

    do_write(9'd130, 16'h1234);
    do_read(9'd40, 1'b0);
    do_write(9'd20, 16'h5555);
    do_read(9'd47, 1'b1);
    do_read(9'd47, 1'b0);
    do_write(9'd176, 16'hC0DE);
    do_read(9'd176, 1'b0);
    do_write(9'd127, 16'h0BAD);
    do_write(9'd128, 16'h0128);
    do_read(9'd128, 1'b1);

    // Both strobes low together: one error, no BRAM access.
    s_ce = tot_ce;
    i_xintf_cs_n = 1'b0; i_xintf_we_n = 1'b0; i_xintf_rd_n = 1'b0;
    repeat (6) step();
    i_xintf_cs_n = 1'b1; i_xintf_we_n = 1'b1; i_xintf_rd_n = 1'b1;
    repeat (6) step();
    if (ref_err < 255) ref_err++;
    check("both_low_err", 32'(o_err_cnt), ref_err);
    check("both_low_no_ce", tot_ce - s_ce, 32'd0);
    check("both_low_idle", 32'(o_state), 32'd0);

    // Randomized mix of reads and writes across both regions.
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 7));
      d = 16'($urandom);
      if (k == 0) do_read(9'd47, 1'($urandom_range(0, 1)));
      else if (k == 1) do_write(9'd176, d);
      else begin
        a = 9'($urandom_range(0, 255));
        if (k < 5) do_write(a, d);
        else do_read(a, 1'($urandom_range(0, 1)));
      end
    end

    // Error counter saturation.
    s_we = tot_we;
    k = tot_we;
    for (int n = 0; n < 300; n++) begin
      bus_op(1'b1, 9'd5, 16'($urandom), 4);
      if (ref_err < 255) ref_err++;
    end
    check("sat_err_cnt", 32'(o_err_cnt), ref_err);
    check("sat_err_is_255", 32'(o_err_cnt), 32'd255);
    check("sat_no_we", tot_we - k, 32'd0);

    // Reset while in RD_DATA.
    i_xintf_addr = 9'd200; i_xintf_cs_n = 1'b0; i_xintf_rd_n = 1'b0;
    k = 0;
    while (o_state != 3'd3 && k < 12) begin step(); k++; end
    check("rst_reach_rd_data", 32'(o_state), 32'd3);
    i_rst = 1'b0;
    #1;
    check("rst_rd_data_state", 32'(o_state), 32'd0);
    check("rst_rd_data_oe", 32'(o_xintf_data_oe), 32'd0);
    check("rst_rd_data_out", 32'(o_xintf_data_out), 32'd0);
    i_xintf_cs_n = 1'b1; i_xintf_rd_n = 1'b1;
    repeat (3) step();
    i_rst = 1'b1;
    ref_err = 0;
    repeat (3) step();
    check("rst_err_cleared", 32'(o_err_cnt), 32'd0);

    // Reset while the pad is driving read data.
    i_xintf_addr = 9'd40; i_xintf_cs_n = 1'b0; i_xintf_rd_n = 1'b0;
    k = 0;
    while (o_xintf_data_oe != 1'b1 && k < 12) begin step(); k++; end
    check("rst_reach_oe", 32'(o_xintf_data_oe), 32'd1);
    i_rst = 1'b0;
    #1;
    check("rst_oe_cleared", 32'(o_xintf_data_oe), 32'd0);
    check("rst_data_cleared", 32'(o_xintf_data_out), 32'd0);
    i_xintf_cs_n = 1'b1; i_xintf_rd_n = 1'b1;
    repeat (3) step();
    i_rst = 1'b1;
    repeat (3) step();

    do_read(9'd40, 1'b0);
    do_write(9'd250, 16'hA5A5);
    do_read(9'd250, 1'b0);

    check("no_consecutive_pulses", consec, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xintf_dsp_bridge.md
Name: xintf_dsp_bridge

Overview:
- DSP-side front end of the XINTF dual-port BRAM shared with the FPGA-side DSP handler.
- Synchronises the asynchronous TMS320 XINTF strobes into i_clk and converts DSP bus cycles into BRAM port-B accesses.
- Region 0..127 holds FPGA-to-DSP data and is DSP read-only; region 128..255 holds DSP-to-FPGA data and is DSP read/write.
- Generates the block-transfer handshakes consumed by the handler: o_w_ready (DSP has taken the FPGA block) and o_r_valid (DSP has committed a new block).

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the strobe synchronisers (minimum 2).
- W_ACK_ADDR, 47, DSP read of this address completes the FPGA-to-DSP block.
- R_COMMIT_ADDR, 176, DSP write to this address commits the DSP-to-FPGA block.
- WR_BASE, 128, lowest DSP-writable address.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active low.
- i_xintf_cs_n  in  1  XINTF zone chip select, async.
- i_xintf_we_n  in  1  XINTF write strobe, async.
- i_xintf_rd_n  in  1  XINTF read strobe, async.
- i_xintf_addr  in  9  XINTF word address.
- i_xintf_data_in  in  16  XINTF write data.
- o_xintf_data_out  out  16  XINTF read data.
- o_xintf_data_oe  out  1  pad output enable for the data bus.
- o_ram_addr  out  9  BRAM port-B address.
- o_ram_din  out  16  BRAM port-B write data.
- o_ram_ce  out  1  BRAM port-B enable.
- o_ram_we  out  1  BRAM port-B write enable.
- i_ram_dout  in  16  BRAM port-B read data; 1-cycle latency.
- i_w_valid  in  1  handler holds a complete FPGA-to-DSP block (level).
- o_w_ready  out  1  one-cycle pulse: DSP has consumed the block.
- o_r_valid  out  1  one-cycle pulse: DSP has committed a new block.
- o_err_cnt  out  8  saturating count of illegal bus cycles.
- o_state  out  3  FSM state, for debug.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, and every synchroniser stage is 1 (strobes inactive).
- Synchronisers: cs_n, we_n and rd_n each pass through SYNC_STAGES flip-flops.
  - A start is a synced 1->0 edge of we_n or rd_n while synced cs_n = 0.
  - Address and data are sampled on the start cycle; the DSP holds them stable throughout the strobe.
- FSM states and transitions:
  - IDLE (0): a write start goes to WR_CAP; a read start goes to RD_ADDR.
    - If we_n and rd_n are both low with cs_n low, stay in IDLE, increment o_err_cnt and wait until both are high.
  - WR_CAP (1): if addr >= WR_BASE, drive o_ram_ce = o_ram_we = 1 for exactly this cycle with the sampled addr/data.
    - If addr < WR_BASE, issue no RAM access and increment o_err_cnt.
    - If addr == R_COMMIT_ADDR, pulse o_r_valid for this cycle. The data is still written, since the address is >= WR_BASE.
    - Next state: WAIT_END.
  - RD_ADDR (2): drive o_ram_ce = 1 with o_ram_addr = sampled addr. Next state: RD_DATA.
  - RD_DATA (3): latch i_ram_dout into o_xintf_data_out and set o_xintf_data_oe = 1. Next state: WAIT_END.
  - WAIT_END (4): hold data_out/oe. When synced rd_n and we_n are both 1:
    - clear oe;
    - if the finished cycle was a read of W_ACK_ADDR and i_w_valid = 1, pulse o_w_ready for 1 cycle;
    - return to IDLE.
- Latencies:
  - Write reaches the BRAM SYNC_STAGES+1 cycles after the we_n falling edge.
  - Read data is valid at the pad SYNC_STAGES+3 cycles after the rd_n falling edge. DSP XINTF read-active timing must exceed this.
- A read of W_ACK_ADDR with i_w_valid = 0 is served normally, with no pulse and no error.
- o_ram_ce/o_ram_we/o_r_valid/o_w_ready are never high for more than 1 consecutive cycle per bus cycle.
- o_err_cnt saturates at 255 and never wraps.
- cs_n rising mid-cycle is ignored; the cycle ends only on strobe release.
- Asynchronous reset mid-cycle: outputs clear immediately; any in-flight write is dropped; FSM restarts in IDLE.

Test Plan:
- DSP write addr=130, data=0x1234 -> exactly one o_ram_we cycle with addr 130 / din 0x1234 three cycles after we_n falls; o_err_cnt stays 0.
- Preload BRAM[40]=0xBEEF, DSP read addr 40 -> o_xintf_data_out=0xBEEF with oe=1 five cycles after rd_n falls; oe=0 after rd_n is synced high.
- DSP write addr=20 -> no o_ram_we; o_err_cnt goes 0->1.
- i_w_valid=1, DSP read addr 47 -> single o_w_ready pulse after rd_n release. Repeat with i_w_valid=0 -> no pulse.
- DSP write addr 176 -> BRAM[176] written and a one-cycle o_r_valid pulse. 300 writes to addr 5 -> o_err_cnt=255.
- Assert i_rst low during RD_DATA -> oe and data_out go 0 at once. Release reset and issue a new read -> served correctly.
